// File: rtl/is_pkg.sv
// is_pkg: issue-stage constants.
// IS_ENTRIES is the per-unit queue depth, NUM_OF_FU the number of
// functional units, and FU_* name the fixed channel positions.
package is_pkg;

   localparam int IS_ENTRIES = 4;
   localparam int NUM_OF_FU  = 4;

   localparam int FU_LSU = 0;
   localparam int FU_BRU = 1;
   localparam int FU_ALU = 2;
   localparam int FU_FPU = 3;

endpackage : is_pkg

// File: rtl/rob_pkg.sv
// rob_pkg: types shared with the reorder buffer.
// rob_issue is the payload carried from a ROB issue port to a functional
// unit; its packed width sets the payload width of the issue queues.
package rob_pkg;

   typedef struct packed {
      logic [5:0] rob_tag;   // ROB slot that owns the instruction
      logic [5:0] opcode;    // decoded operation for the functional unit
      logic [3:0] src_sel;   // operand source selects
   } rob_issue;

endpackage : rob_pkg

// File: rtl/is_fifo_channel.sv
// is_fifo_channel: one circular issue FIFO feeding a single functional unit.
//
// Ports:
//   clk_in, rst_in (sync, active-high), flush_in (sync squash)
//   in_valid_in / in_data_in / in_ready_out   : enqueue handshake from ROB
//   fu_valid_out / fu_data_out / fu_ready_in  : dequeue handshake to FU
//   executing_out : registered pulse, one cycle after each hand-off to the FU
//   count_out     : current occupancy, 0..DEPTH
//
// Build option: IS_QUEUE_BYPASS_EN. When defined, an empty queue whose FU is
// ready hands an incoming instruction straight through in the same cycle
// without storing it. When undefined, all outputs derive from state only.
module is_fifo_channel #(
   parameter int DEPTH   = 4,
   parameter int ENTRY_W = 16
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         flush_in,
   input  logic                         in_valid_in,
   input  logic [ENTRY_W-1:0]           in_data_in,
   output logic                         in_ready_out,
   input  logic                         fu_ready_in,
   output logic                         fu_valid_out,
   output logic [ENTRY_W-1:0]           fu_data_out,
   output logic                         executing_out,
   output logic [$clog2(DEPTH+1)-1:0]   count_out
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]      r_head;
   logic [PW-1:0]      r_tail;
   logic [CW-1:0]      r_count;
   logic               r_exec;

   logic w_not_empty;
   logic w_bypass;
   logic w_enq;
   logic w_pop;

   assign w_not_empty  = (r_count != '0);
   // Readiness looks at occupancy only: a full queue refuses input even in a
   // cycle where it also pops.
   assign in_ready_out = (r_count != FULL_COUNT);

`ifdef IS_QUEUE_BYPASS_EN
   assign w_bypass     = !w_not_empty && in_valid_in && fu_ready_in;
   assign fu_valid_out = w_not_empty || w_bypass;
   assign fu_data_out  = w_not_empty ? r_mem[r_head] : in_data_in;
`else
   assign w_bypass     = 1'b0;
   assign fu_valid_out = w_not_empty;
   assign fu_data_out  = r_mem[r_head];
`endif

   // A bypassed instruction never touches storage.
   assign w_enq = in_valid_in && in_ready_out && !w_bypass && !flush_in && !rst_in;
   assign w_pop = w_not_empty && fu_ready_in && !flush_in;

   // Storage is deliberately left out of reset; pointers define validity.
   always_ff @(posedge clk_in) begin
      if (w_enq) begin
         r_mem[r_tail] <= in_data_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in || flush_in) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_exec  <= 1'b0;
      end else begin
         if (w_enq) begin
            r_tail <= r_tail + PW'(1);
         end
         if (w_pop) begin
            r_head <= r_head + PW'(1);
         end
         unique case ({w_enq, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         r_exec <= w_pop || w_bypass;
      end
   end

   assign executing_out = r_exec;
   assign count_out     = r_count;

endmodule : is_fifo_channel

// File: rtl/is_multi_queue.sv
// is_multi_queue: per-functional-unit issue buffer between the ROB issue
// ports and the execution units. NUM_FU independent FIFOs, no arbitration.
//
// Ports (channel c uses slice [c*ENTRY_W +: ENTRY_W] of the data buses and
// [c*$clog2(DEPTH+1) +: $clog2(DEPTH+1)] of count_out):
//   clk_in, rst_in (sync, active-high), flush_in (sync squash of all channels)
//   in_valid_in, in_data_in, in_ready_out   : ROB-side handshake
//   fu_ready_in, fu_valid_out, fu_data_out  : FU-side handshake
//   executing_out : one-cycle acknowledgement after each hand-off
//   count_out     : per-channel occupancy
//
// Build option: IS_QUEUE_BYPASS_EN enables the empty-queue same-cycle
// bypass inside each channel.
module is_multi_queue
   import is_pkg::*;
   import rob_pkg::*;
#(
   parameter int NUM_FU  = NUM_OF_FU,
   parameter int DEPTH   = IS_ENTRIES,
   parameter int ENTRY_W = $bits(rob_issue)
) (
   input  logic                                 clk_in,
   input  logic                                 rst_in,
   input  logic                                 flush_in,
   input  logic [NUM_FU-1:0]                    in_valid_in,
   input  logic [NUM_FU*ENTRY_W-1:0]            in_data_in,
   output logic [NUM_FU-1:0]                    in_ready_out,
   input  logic [NUM_FU-1:0]                    fu_ready_in,
   output logic [NUM_FU-1:0]                    fu_valid_out,
   output logic [NUM_FU*ENTRY_W-1:0]            fu_data_out,
   output logic [NUM_FU-1:0]                    executing_out,
   output logic [NUM_FU*$clog2(DEPTH+1)-1:0]    count_out
);

   localparam int CW = $clog2(DEPTH+1);

   for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_chan
      is_fifo_channel #(
         .DEPTH   (DEPTH),
         .ENTRY_W (ENTRY_W)
      ) u_chan (
         .clk_in        (clk_in),
         .rst_in        (rst_in),
         .flush_in      (flush_in),
         .in_valid_in   (in_valid_in[gi]),
         .in_data_in    (in_data_in[gi*ENTRY_W +: ENTRY_W]),
         .in_ready_out  (in_ready_out[gi]),
         .fu_ready_in   (fu_ready_in[gi]),
         .fu_valid_out  (fu_valid_out[gi]),
         .fu_data_out   (fu_data_out[gi*ENTRY_W +: ENTRY_W]),
         .executing_out (executing_out[gi]),
         .count_out     (count_out[gi*CW +: CW])
      );
   end

endmodule : is_multi_queue
